// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline stage register with a one-entry skid buffer.
// Holds up to two beats in order, masks ctrl on bubbles and counts downstream stall cycles.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_main_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_stall;
  logic w_cnt_max;

  assign w_stall   = r_main_valid & ~out_ready;
  assign w_cnt_max = &r_stall_cnt;

  // in_ready depends only on registered state, so upstream never sees a path from out_ready.
  assign in_ready  = (r_state != SKID);
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;
  assign occupancy = (r_state == SKID) ? 2'd2 : ((r_state == FULL) ? 2'd1 : 2'd0);
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end else if (flush) begin
      // Only the valid bits drop; payload registers keep their last contents.
      r_state      <= EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (in_valid) begin
            r_main_data  <= in_data;
            r_main_ctrl  <= in_ctrl;
            r_main_valid <= 1'b1;
            r_state      <= FULL;
          end
        end
        FULL: begin
          if (in_valid && out_ready) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (in_valid) begin
            r_skid_data  <= in_data;
            r_skid_ctrl  <= in_ctrl;
            r_skid_valid <= 1'b1;
            r_state      <= SKID;
          end else if (out_ready) begin
            r_main_valid <= 1'b0;
            r_state      <= EMPTY;
          end
        end
        SKID: begin
          if (out_ready) begin
            r_main_data  <= r_skid_data;
            r_main_ctrl  <= r_skid_ctrl;
            r_skid_valid <= 1'b0;
            r_state      <= FULL;
          end
        end
        default: begin
          r_state      <= EMPTY;
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stall counter saturates and survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_cnt_max) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
